// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the pipeline stage register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam logic [7:0] BUBBLE_MAX = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// ============================================================================
// Module      : pipe_slot
// Description : One valid+ctrl+data storage slot; ctrl masked while empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_slot #(
  parameter int                DATA_W   = 16,
  parameter int                CTRL_W   = 8,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_kill,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Kill wins over load so a flushed cycle never captures a payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_RST;
      r_data  <= '0;
    end else begin
      if (i_kill) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= 1'b1;
        r_ctrl  <= i_ctrl;
        r_data  <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_valid ? r_ctrl : CTRL_RST;
  assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module      : pipe_stage_reg
// Description : Inter-stage register with valid/ready, optional skid, flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                CTRL_W   = 8,
  parameter int                SKID     = 1,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [7:0]        bubble_cnt
);

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_main_load;
  logic              w_main_kill;
  logic              w_main_valid;
  logic [CTRL_W-1:0] w_main_ctrl_d;
  logic [DATA_W-1:0] w_main_data_d;
  logic [7:0]        r_bubble_cnt;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  pipe_slot #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .CTRL_RST (CTRL_RST)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_main_load),
    .i_kill  (w_main_kill),
    .i_ctrl  (w_main_ctrl_d),
    .i_data  (w_main_data_d),
    .o_valid (w_main_valid),
    .o_ctrl  (out_ctrl),
    .o_data  (out_data)
  );

  assign out_valid = w_main_valid;

  generate
    if (SKID != 0) begin : g_skid
      pipe_state_e       r_state;
      logic              w_skid_load;
      logic              w_skid_kill;
      logic              w_skid_valid;
      logic [CTRL_W-1:0] w_skid_ctrl;
      logic [DATA_W-1:0] w_skid_data;

      pipe_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_RST (CTRL_RST)
      ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_kill  (w_skid_kill),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
      );

      // Pure state decode keeps out_ready out of the upstream ready path.
      assign in_ready  = (r_state != TWO);
      assign occupancy = {w_main_valid & w_skid_valid, w_main_valid ^ w_skid_valid};

      always_comb begin
        w_main_load   = 1'b0;
        w_main_kill   = 1'b0;
        w_skid_load   = 1'b0;
        w_skid_kill   = 1'b0;
        w_main_ctrl_d = in_ctrl;
        w_main_data_d = in_data;
        if (flush) begin
          w_main_kill = 1'b1;
          w_skid_kill = 1'b1;
        end else begin
          case (r_state)
            EMPTY: w_main_load = w_in_fire;
            ONE: begin
              if (w_in_fire && w_out_fire) w_main_load = 1'b1;
              else if (w_in_fire)          w_skid_load = 1'b1;
              else if (w_out_fire)         w_main_kill = 1'b1;
            end
            TWO: begin
              if (w_out_fire) begin
                w_main_load   = 1'b1;
                w_skid_kill   = 1'b1;
                w_main_ctrl_d = w_skid_ctrl;
                w_main_data_d = w_skid_data;
              end
            end
            default: ;
          endcase
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_state <= EMPTY;
        end else if (flush) begin
          r_state <= EMPTY;
        end else begin
          case (r_state)
            EMPTY: if (w_in_fire) r_state <= ONE;
            ONE: begin
              if (w_in_fire && !w_out_fire)      r_state <= TWO;
              else if (!w_in_fire && w_out_fire) r_state <= EMPTY;
            end
            TWO:     if (w_out_fire) r_state <= ONE;
            default: r_state <= EMPTY;
          endcase
        end
      end
    end else begin : g_single
      assign in_ready      = !w_main_valid | out_ready;
      assign occupancy     = {1'b0, w_main_valid};
      assign w_main_ctrl_d = in_ctrl;
      assign w_main_data_d = in_data;
      assign w_main_load   = w_in_fire & !flush;
      assign w_main_kill   = flush | (w_out_fire & !w_in_fire);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bubble_cnt <= '0;
    end else if (!out_valid && out_ready && (r_bubble_cnt != BUBBLE_MAX)) begin
      r_bubble_cnt <= r_bubble_cnt + 8'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised successor to the fixed inter-stage latches (IF/ID … MEM/WB). It carries one pipeline payload split into two fields:
- a CTRL field (RegWrite, memWrite, halt, …) that is forced to zero whenever the slot is empty or flushed;
- a DATA field (PC, ALU result, immediates, …) that is only loaded, never cleared.

It adds a valid/ready handshake with an optional 2-entry skid buffer, so a stage can stall without a combinational ready path back through the pipeline. Flush inserts bubbles.

Parameters:
DATA_W, 16, width of data payload (no clear on flush)
CTRL_W, 8, width of control payload (zeroed when slot invalid)
SKID, 1, 1 = 2-entry skid (registered in_ready); 0 = single slot, in_ready combinational
CTRL_RST, {CTRL_W{1'b0}}, control value presented while out_valid=0

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
flush  in  1  synchronous kill of all held entries and of any same-cycle input
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept this cycle
in_ctrl  in  CTRL_W  upstream control field
in_data  in  DATA_W  upstream data field
out_valid  out  1  downstream payload valid
out_ready  in  1  downstream accepts (0 = stall)
out_ctrl  out  CTRL_W  control; equals CTRL_RST when out_valid=0
out_data  out  DATA_W  data; undefined-but-stable when out_valid=0
occupancy  out  2  entries held (0..2; max 1 when SKID=0)
bubble_cnt  out  8  saturating count of cycles with out_valid=0 & out_ready=1; cleared only by rst

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (rst=0, async): state EMPTY, out_valid=0, out_ctrl=CTRL_RST, out_data=0, occupancy=0, bubble_cnt=0. in_ready=1 during and after reset.
- Reset mid-operation drops all held entries immediately, without waiting for a clock edge.
- SKID=1 FSM (main slot drives outputs, skid slot hidden):
  - EMPTY: in_fire -> ONE, main<=in.
  - ONE: in_fire & out_fire -> ONE, main<=in. in_fire & !out_ready -> TWO, skid<=in. !in_fire & out_fire -> EMPTY. Otherwise hold.
  - TWO: in_ready=0. out_fire -> ONE, main<=skid. Otherwise hold.
  - in_ready = (state != TWO), driven from a flop or a pure state decode only, never from out_ready.
- SKID=0: single slot. in_ready = !out_valid | out_ready. On in_fire, slot<=in. On out_fire without in_fire, slot empties.
- Latency: 1 cycle from in_fire to out_valid when empty; throughput 1/cycle with out_ready held high.
- Stall: out_ready=0 holds out_ctrl/out_data bit-stable; no payload is lost or duplicated.
- Flush (sync, highest priority):
  - Next edge: state EMPTY, occupancy 0, out_valid 0, out_ctrl=CTRL_RST.
  - An in_fire in the flush cycle is discarded; in_ready still reads 1 so upstream drops it.
  - out_data is not cleared.
- flush with out_fire in the same cycle: the downstream consumes the current entry, then the stage empties.
- bubble_cnt saturates at 8'hFF and does not wrap.
- Ordering: entries leave strictly in arrival order (main before skid).

Decomposition:
- Package pipe_pkg:
  - typedef for the state enum {EMPTY, ONE, TWO};
  - localparam BUBBLE_MAX = 8'hFF.
- Sub-module pipe_slot: one valid+ctrl+data storage slot with load enable and async active-low clear.
  - Instantiated twice (main, skid); once when SKID=0.
  - Handles CTRL_RST masking on its outputs.

Test Plan:
- Reset/flow: rst low 3 cycles, then 4 inputs ctrl=8'h01..04, data=16'hA000..A003, out_ready=1. Expect outputs match 1 cycle later, back-to-back, occupancy=1, in_ready=1 throughout.
- Stall fill: out_ready=0 while sending ctrl 8'h11, 8'h22. Expect occupancy=2, in_ready=0, out_ctrl=8'h11 held. Then out_ready=1: expect 8'h11 then 8'h22, with in_ready=1 returning one cycle after the first out_fire.
- Flush: from occupancy=2, assert flush with in_valid=1 (ctrl 8'h33). Next cycle expect out_valid=0, out_ctrl=8'h00, occupancy=0, and 8'h33 never appears.
- Async reset mid-stream: drop rst between edges with occupancy=2. Expect out_valid=0 and out_ctrl=0 immediately; bubble_cnt=0.
- SKID=0 instance: out_ready=0 with a slot full. Expect in_ready=0 combinationally. Raise out_ready and in_valid in the same cycle: in_ready=1 and the new entry replaces the old at the edge.
- Bubble count: 300 idle cycles with out_ready=1 and no input. Expect bubble_cnt=8'hFF, held (no wrap).
